counter_cfg_sequencer: RTL and testbench

Bus-master controller that programs and runs the 8-bit up/down counter through its ncs/nwr/nrd/A1:A0 register interface.
- On a request, captures four configuration bytes and writes them to counter registers 0..3.
- Pulses start, then supervises the run until end-count (ec), counter error (err), timeout or abort.
- Sits between system control logic and the counter; it is the only block that drives the counter's bus pins.

---
 rtl/counter_cfg_pkg.sv | 29 ++
 rtl/ctr_bus_cycle.sv | 101 ++++++++++
 rtl/counter_cfg_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_counter_cfg_sequencer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_cfg_pkg.sv
// counter_cfg_pkg: shared types and constants for the counter configuration sequencer.
//   state_t   - sequencer / bus-cycle states
//   REG_0..3  - counter register addresses (A1:A0)
//   ERR_*     - err_code values reported by the sequencer
package counter_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        ARM,
        RUN,
        FINISH,
        FAIL
    } state_t;

    localparam logic [1:0] REG_0 = 2'd0;
    localparam logic [1:0] REG_1 = 2'd1;
    localparam logic [1:0] REG_2 = 2'd2;
    localparam logic [1:0] REG_3 = 2'd3;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_CTR     = 3'd1;
    localparam logic [2:0] ERR_TIMEOUT = 3'd2;
    localparam logic [2:0] ERR_ABORT   = 3'd3;
    localparam logic [2:0] ERR_VERIFY  = 3'd4;

endpackage

// File: rtl/ctr_bus_cycle.sv
// ctr_bus_cycle: executes one read or write cycle on the counter bus.
//   SETUP (1 cycle) -> STROBE (WAIT_STATES cycles, nwr or nrd low) -> HOLD (1 cycle).
//   A new go during HOLD chains the next cycle with no gap; otherwise the pins
//   return to idle (strobes high, address and data zero).
// Ports:
//   clk, reset     - clock, asynchronous active-high reset
//   clear          - synchronous abort: drop the cycle and idle the pins
//   go, rnw        - launch a cycle (accepted in IDLE or HOLD); rnw=1 selects a read
//   go_addr        - register address for the launched cycle
//   go_data        - write data for the launched cycle
//   rdata          - counter read data, sampled on the last STROBE cycle of a read
//   nwr, nrd       - active-low write / read strobes
//   addr, din      - registered address and write data
//   rdata_q        - captured read data, valid during HOLD of a read
//   cycle_done     - high during HOLD
module ctr_bus_cycle
    import counter_cfg_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       go,
    input  logic       rnw,
    input  logic [1:0] go_addr,
    input  logic [7:0] go_data,
    input  logic [7:0] rdata,
    output logic       nwr,
    output logic       nrd,
    output logic [1:0] addr,
    output logic [7:0] din,
    output logic [7:0] rdata_q,
    output logic       cycle_done
);

    state_t     phase;
    logic       rnw_q;
    logic [2:0] ws_cnt;

    assign cycle_done = (phase == HOLD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase   <= IDLE;
            nwr     <= 1'b1;
            nrd     <= 1'b1;
            addr    <= REG_0;
            din     <= 8'h00;
            rdata_q <= 8'h00;
            rnw_q   <= 1'b0;
            ws_cnt  <= 3'd0;
        end else if (clear) begin
            phase  <= IDLE;
            nwr    <= 1'b1;
            nrd    <= 1'b1;
            addr   <= REG_0;
            din    <= 8'h00;
            rnw_q  <= 1'b0;
            ws_cnt <= 3'd0;
        end else begin
            case (phase)
                SETUP: begin
                    phase  <= STROBE;
                    ws_cnt <= 3'd1;
                    nwr    <= rnw_q;
                    nrd    <= ~rnw_q;
                end
                STROBE: begin
                    if (ws_cnt == 3'(WAIT_STATES)) begin
                        phase <= HOLD;
                        nwr   <= 1'b1;
                        nrd   <= 1'b1;
                        // The edge ending the last strobe cycle sees the data
                        // the counter drove during that cycle.
                        if (rnw_q) begin
                            rdata_q <= rdata;
                        end
                    end else begin
                        ws_cnt <= ws_cnt + 3'd1;
                    end
                end
                default: begin
                    // IDLE or HOLD: launch the next cycle or release the bus.
                    if (go) begin
                        phase <= SETUP;
                        addr  <= go_addr;
                        din   <= rnw ? 8'h00 : go_data;
                        rnw_q <= rnw;
                    end else begin
                        phase <= IDLE;
                        addr  <= REG_0;
                        din   <= 8'h00;
                        rnw_q <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/counter_cfg_sequencer.sv
// counter_cfg_sequencer: programs counter registers 0..3 over the ncs/nwr/nrd bus,
// pulses start and supervises the run until end-count, counter error, timeout or abort.
// Optional feature macro: READBACK_VERIFY_EN - when defined, a read-back pass over
// registers 0..3 follows the writes and any mismatch fails the sequence before start.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   req, abort          - start a sequence (IDLE only) / cancel an active one
//   cfg_r0..cfg_r3      - configuration bytes for registers 0..3
//   ctr_rdata           - counter read data (read-back pass only)
//   ctr_ec, ctr_err     - counter end-count and error flags
//   ctr_din, ctr_ncs, ctr_nwr, ctr_nrd, ctr_a0, ctr_a1 - counter bus
//   ctr_start           - counter start
//   busy, done, error   - status; done/error are one-cycle pulses
//   err_code            - failure reason, held until the next accepted req
module counter_cfg_sequencer
    import counter_cfg_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       abort,
    input  logic [7:0] cfg_r0,
    input  logic [7:0] cfg_r1,
    input  logic [7:0] cfg_r2,
    input  logic [7:0] cfg_r3,
    input  logic [7:0] ctr_rdata,
    input  logic       ctr_ec,
    input  logic       ctr_err,
    output logic [7:0] ctr_din,
    output logic       ctr_ncs,
    output logic       ctr_nwr,
    output logic       ctr_nrd,
    output logic       ctr_a0,
    output logic       ctr_a1,
    output logic       ctr_start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] err_code
);

`ifdef READBACK_VERIFY_EN
    localparam bit READBACK_EN = 1'b1;
`else
    localparam bit READBACK_EN = 1'b0;
`endif

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    // SETUP here spans the whole register-access phase; the per-cycle
    // SETUP/STROBE/HOLD detail lives in ctr_bus_cycle.
    state_t      state;
    logic [1:0]  addr;
    logic [7:0]  cfg_q [4];
    logic        reading;
    logic [15:0] tcnt;

    logic        go;
    logic        go_rnw;
    logic [1:0]  go_addr;
    logic [7:0]  go_data;
    logic        abort_hit;
    logic        verify_bad;
    logic        bus_done;
    logic [1:0]  bus_addr;
    logic [7:0]  bus_rdata;

    always_comb begin
        // FINISH and FAIL already end the sequence on their own next cycle.
        abort_hit  = abort && ((state == SETUP) || (state == ARM) || (state == RUN));
        verify_bad = reading && bus_done && (bus_rdata != cfg_q[addr]);
        go         = 1'b0;
        go_rnw     = reading;
        go_addr    = addr;
        go_data    = cfg_q[addr];
        if (!abort_hit) begin
            if ((state == IDLE) && req) begin
                go      = 1'b1;
                go_rnw  = 1'b0;
                go_addr = REG_0;
                go_data = cfg_r0;
            end else if ((state == SETUP) && bus_done && !verify_bad) begin
                if (addr != REG_3) begin
                    go      = 1'b1;
                    go_addr = addr + 2'd1;
                    go_data = cfg_q[addr + 2'd1];
                end else if (READBACK_EN && !reading) begin
                    go      = 1'b1;
                    go_rnw  = 1'b1;
                    go_addr = REG_0;
                    go_data = 8'h00;
                end
            end
        end
    end

    ctr_bus_cycle #(
        .WAIT_STATES(WAIT_STATES)
    ) u_bus (
        .clk       (clk),
        .reset     (reset),
        .clear     (abort_hit),
        .go        (go),
        .rnw       (go_rnw),
        .go_addr   (go_addr),
        .go_data   (go_data),
        .rdata     (ctr_rdata),
        .nwr       (ctr_nwr),
        .nrd       (ctr_nrd),
        .addr      (bus_addr),
        .din       (ctr_din),
        .rdata_q   (bus_rdata),
        .cycle_done(bus_done)
    );

    assign ctr_a0 = bus_addr[0];
    assign ctr_a1 = bus_addr[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= REG_0;
            for (int i = 0; i < 4; i++) begin
                cfg_q[i] <= 8'h00;
            end
            reading   <= 1'b0;
            tcnt      <= 16'd0;
            ctr_ncs   <= 1'b1;
            ctr_start <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (abort_hit) begin
                state     <= FAIL;
                ctr_ncs   <= 1'b1;
                ctr_start <= 1'b0;
                error     <= 1'b1;
                err_code  <= ERR_ABORT;
            end else begin
                case (state)
                    IDLE: begin
                        if (req) begin
                            cfg_q[0] <= cfg_r0;
                            cfg_q[1] <= cfg_r1;
                            cfg_q[2] <= cfg_r2;
                            cfg_q[3] <= cfg_r3;
                            err_code <= ERR_NONE;
                            addr     <= REG_0;
                            reading  <= 1'b0;
                            ctr_ncs  <= 1'b0;
                            busy     <= 1'b1;
                            state    <= SETUP;
                        end
                    end
                    SETUP: begin
                        if (bus_done) begin
                            if (verify_bad) begin
                                state    <= FAIL;
                                ctr_ncs  <= 1'b1;
                                error    <= 1'b1;
                                err_code <= ERR_VERIFY;
                            end else if (addr != REG_3) begin
                                addr <= addr + 2'd1;
                            end else if (READBACK_EN && !reading) begin
                                reading <= 1'b1;
                                addr    <= REG_0;
                            end else begin
                                state     <= ARM;
                                reading   <= 1'b0;
                                ctr_ncs   <= 1'b1;
                                ctr_start <= 1'b1;
                                tcnt      <= 16'd0;
                            end
                        end
                    end
                    ARM: begin
                        state <= RUN;
                    end
                    RUN: begin
                        if (ctr_err) begin
                            state     <= FAIL;
                            ctr_start <= 1'b0;
                            error     <= 1'b1;
                            err_code  <= ERR_CTR;
                        end else if (ctr_ec) begin
                            state     <= FINISH;
                            ctr_start <= 1'b0;
                            done      <= 1'b1;
                        end else if (tcnt == TIMEOUT_LAST) begin
                            state     <= FAIL;
                            ctr_start <= 1'b0;
                            error     <= 1'b1;
                            err_code  <= ERR_TIMEOUT;
                        end else begin
                            tcnt <= tcnt + 16'd1;
                        end
                    end
                    FINISH, FAIL: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_counter_cfg_sequencer.sv
// Directed bench for counter_cfg_sequencer (WAIT_STATES=1, TIMEOUT=20).
// Cycle 1 is the first cycle after the edge that accepts req.
module tb_counter_cfg_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req, abort;
    logic [7:0] cfg_r0, cfg_r1, cfg_r2, cfg_r3;
    logic [7:0] ctr_rdata;
    logic       ctr_ec, ctr_err;
    logic [7:0] ctr_din;
    logic       ctr_ncs, ctr_nwr, ctr_nrd, ctr_a0, ctr_a1, ctr_start;
    logic       busy, done, error;
    logic [2:0] err_code;

    int n_cmp  = 0;
    int n_fail = 0;

    // {ncs, nwr, nrd, a1, a0, din, start}
    logic [13:0] pins;
    assign pins = {ctr_ncs, ctr_nwr, ctr_nrd, ctr_a1, ctr_a0, ctr_din, ctr_start};
    localparam logic [13:0] PINS_IDLE = {3'b111, 2'b00, 8'h00, 1'b0};

    counter_cfg_sequencer #(
        .WAIT_STATES(1),
        .TIMEOUT    (20)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .abort    (abort),
        .cfg_r0   (cfg_r0),
        .cfg_r1   (cfg_r1),
        .cfg_r2   (cfg_r2),
        .cfg_r3   (cfg_r3),
        .ctr_rdata(ctr_rdata),
        .ctr_ec   (ctr_ec),
        .ctr_err  (ctr_err),
        .ctr_din  (ctr_din),
        .ctr_ncs  (ctr_ncs),
        .ctr_nwr  (ctr_nwr),
        .ctr_nrd  (ctr_nrd),
        .ctr_a0   (ctr_a0),
        .ctr_a1   (ctr_a1),
        .ctr_start(ctr_start),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request; returns in cycle 1.
    task automatic accept(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
        cfg_r0 = d0;
        cfg_r1 = d1;
        cfg_r2 = d2;
        cfg_r3 = d3;
        req    = 1'b1;
        tick();
        req    = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (pins !== PINS_IDLE) begin
            n_fail++;
            $display("FAIL reset_pins: got %h want %h", pins, PINS_IDLE);
        end
        n_cmp++;
        if ({busy, done, error} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_status: got %b want 000", {busy, done, error});
        end
        n_cmp++;
        if (err_code !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_err_code: got %0d want 0", err_code);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_program_run(input logic [7:0] d0, input logic [7:0] d1,
                                    input logic [7:0] d2, input logic [7:0] d3);
        logic [7:0]  d [4];
        logic [13:0] exp_pins;
        int          bad;
        d[0] = d0;
        d[1] = d1;
        d[2] = d2;
        d[3] = d3;
        accept(d0, d1, d2, d3);
        for (int c = 1; c <= 12; c++) begin
            int w;
            int p;
            w = (c - 1) / 3;
            p = (c - 1) % 3;
            exp_pins = {1'b0, (p == 1) ? 1'b0 : 1'b1, 1'b1, 2'(w), d[w], 1'b0};
            n_cmp++;
            if (pins !== exp_pins || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL write_cycle%0d: got pins %h busy %b want pins %h busy 1",
                         c, pins, busy, exp_pins);
            end
            tick();
        end
        // Cycle 13: ARM
        exp_pins = {3'b111, 2'b00, 8'h00, 1'b1};
        n_cmp++;
        if (pins !== exp_pins) begin
            n_fail++;
            $display("FAIL arm_start: got %h want %h", pins, exp_pins);
        end
        bad = 0;
        for (int c = 14; c <= 17; c++) begin
            tick();
            if (ctr_start !== 1'b1 || done !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL run_hold: got %0d bad cycles want 0", bad);
        end
        tick();            // cycle 18, ec raised
        ctr_ec = 1'b1;
        tick();            // cycle 19, FINISH
        ctr_ec = 1'b0;
        n_cmp++;
        if ({done, error, ctr_start, busy, err_code} !== {4'b1001, 3'd0}) begin
            n_fail++;
            $display("FAIL finish: got done %b error %b start %b busy %b code %0d want 1 0 0 1 0",
                     done, error, ctr_start, busy, err_code);
        end
        tick();            // cycle 20, IDLE
        n_cmp++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL after_finish: got done %b busy %b want 0 0", done, busy);
        end
    endtask

    task automatic test_ctr_err();
        accept(8'd10, 8'd10, 8'd15, 8'd2);
        // req pulses while busy must not disturb the sequence.
        for (int c = 1; c < 13; c++) begin
            req = (c >= 2 && c <= 10);
            tick();
        end
        req = 1'b0;
        n_cmp++;
        if (ctr_start !== 1'b1 || ctr_ncs !== 1'b1) begin
            n_fail++;
            $display("FAIL err_arm: got start %b ncs %b want 1 1", ctr_start, ctr_ncs);
        end
        tick();
        tick();
        tick();            // cycle 16, RUN cycle 3
        ctr_err = 1'b1;
        tick();
        ctr_err = 1'b0;
        n_cmp++;
        if ({error, done, ctr_start, err_code} !== {3'b100, 3'd1}) begin
            n_fail++;
            $display("FAIL ctr_err_pulse: got error %b done %b start %b code %0d want 1 0 0 1",
                     error, done, ctr_start, err_code);
        end
        tick();
        n_cmp++;
        if ({error, busy, err_code} !== {2'b00, 3'd1}) begin
            n_fail++;
            $display("FAIL ctr_err_after: got error %b busy %b code %0d want 0 0 1",
                     error, busy, err_code);
        end
    endtask

    task automatic test_timeout();
        int n;
        accept(8'h01, 8'h02, 8'h03, 8'h04);
        n_cmp++;
        if (err_code !== 3'd0) begin
            n_fail++;
            $display("FAIL code_cleared_on_req: got %0d want 0", err_code);
        end
        for (int c = 1; c < 13; c++) tick();
        n_cmp++;
        if (ctr_start !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_arm: got start %b want 1", ctr_start);
        end
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (error === 1'b1) break;
            n++;
        end
        n_cmp++;
        if (n != 20) begin
            n_fail++;
            $display("FAIL timeout_run_cycles: got %0d want 20", n);
        end
        n_cmp++;
        if ({error, ctr_start, err_code} !== {2'b10, 3'd2}) begin
            n_fail++;
            $display("FAIL timeout_pulse: got error %b start %b code %0d want 1 0 2",
                     error, ctr_start, err_code);
        end
        tick();
        n_cmp++;
        if ({busy, err_code} !== {1'b0, 3'd2}) begin
            n_fail++;
            $display("FAIL timeout_held: got busy %b code %0d want 0 2", busy, err_code);
        end
    endtask

    task automatic test_abort_mid();
        int bad;
        accept(8'h11, 8'h22, 8'h33, 8'h44);
        n_cmp++;
        if (err_code !== 3'd0) begin
            n_fail++;
            $display("FAIL abort_code_cleared: got %0d want 0", err_code);
        end
        for (int c = 1; c < 8; c++) tick();
        n_cmp++;
        if ({ctr_nwr, ctr_a1, ctr_a0, ctr_din} !== {1'b0, 2'b10, 8'h33}) begin
            n_fail++;
            $display("FAIL abort_pos: got nwr %b a %b%b din %h want 0 10 33",
                     ctr_nwr, ctr_a1, ctr_a0, ctr_din);
        end
        abort = 1'b1;
        tick();            // cycle 9, FAIL
        abort = 1'b0;
        n_cmp++;
        if (pins !== PINS_IDLE || error !== 1'b1 || err_code !== 3'd3) begin
            n_fail++;
            $display("FAIL abort_fail: got pins %h error %b code %0d want %h 1 3",
                     pins, error, err_code, PINS_IDLE);
        end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (pins !== PINS_IDLE || busy !== 1'b0 || error !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        accept(8'h55, 8'h66, 8'h77, 8'h88);
        for (int c = 1; c < 8; c++) tick();
        #1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (pins !== PINS_IDLE || {busy, error, done} !== 3'b000 || err_code !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got pins %h busy %b code %0d want %h 0 0",
                     pins, busy, err_code, PINS_IDLE);
        end
        tick();
        tick();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pins !== PINS_IDLE || busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_quiet: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_abort_idle();
        abort = 1'b1;
        tick();
        tick();
        abort = 1'b0;
        n_cmp++;
        if (pins !== PINS_IDLE || {busy, error} !== 2'b00 || err_code !== 3'd0) begin
            n_fail++;
            $display("FAIL abort_idle: got pins %h busy %b error %b code %0d want %h 0 0 0",
                     pins, busy, error, err_code, PINS_IDLE);
        end
    endtask

`ifdef READBACK_VERIFY_EN
    task automatic test_readback();
        logic [7:0] d [4];
        int         err_cycle;
        bit         seen_start;
        d[0] = 8'd10;
        d[1] = 8'd10;
        d[2] = 8'd15;
        d[3] = 8'd2;
        err_cycle  = 0;
        seen_start = 1'b0;
        accept(d[0], d[1], d[2], d[3]);
        for (int c = 1; c <= 30; c++) begin
            if (c >= 13 && c <= 24) begin
                int k;
                k = (c - 13) / 3;
                ctr_rdata = (k == 2) ? 8'hEE : d[k];
            end else begin
                ctr_rdata = 8'h00;
            end
            if (ctr_start === 1'b1) seen_start = 1'b1;
            if (error === 1'b1 && err_cycle == 0) err_cycle = c;
            if (c == 14) begin
                n_cmp++;
                if ({ctr_nrd, ctr_nwr, ctr_ncs} !== 3'b010) begin
                    n_fail++;
                    $display("FAIL rb_strobe: got nrd %b nwr %b ncs %b want 0 1 0",
                             ctr_nrd, ctr_nwr, ctr_ncs);
                end
            end
            tick();
        end
        n_cmp++;
        if (err_cycle != 22) begin
            n_fail++;
            $display("FAIL rb_err_cycle: got %0d want 22", err_cycle);
        end
        n_cmp++;
        if (err_code !== 3'd4 || seen_start) begin
            n_fail++;
            $display("FAIL rb_code: got code %0d start_seen %b want 4 0", err_code, seen_start);
        end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        req       = 1'b0;
        abort     = 1'b0;
        cfg_r0    = 8'h00;
        cfg_r1    = 8'h00;
        cfg_r2    = 8'h00;
        cfg_r3    = 8'h00;
        ctr_rdata = 8'h00;
        ctr_ec    = 1'b0;
        ctr_err   = 1'b0;
        test_reset();
`ifdef READBACK_VERIFY_EN
        test_readback();
`else
        test_program_run(8'd10, 8'd10, 8'd15, 8'd2);
        test_program_run(8'hA5, 8'h5A, 8'hFF, 8'h00);
        test_ctr_err();
        test_timeout();
        test_abort_mid();
        test_reset_mid();
        test_abort_idle();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
